// File: rtl/state_dump_reader.sv
// ============================================================================
// state_dump_reader : streams register file then data memory as tagged beats
// Revision 1.0
// ============================================================================
`default_nettype none

module state_dump_reader #(
   parameter int REG_COUNT = 32,
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  reg_a,
   input  logic [31:0] reg_rd,
   output logic [31:0] mem_a,
   input  logic [31:0] mem_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [15:0] out_index,
   output logic [31:0] out_data
);

   localparam logic [15:0] REG_LAST = 16'(REG_COUNT - 1);
   localparam logic [15:0] MEM_LAST = 16'(MEM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REGS  = 3'd1,
      S_MEM   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic        valid_q, valid_d;
   logic        kind_q, kind_d;
   logic [15:0] index_q, index_d;
   logic [31:0] data_q, data_d;
   logic        cap;

   always_comb begin
      // A beat slot is free when empty or being accepted on this edge.
      cap     = !valid_q || out_ready;
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      kind_d  = kind_q;
      index_d = index_q;
      data_d  = data_q;
      reg_a   = 5'd0;
      mem_a   = 32'd0;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REGS;
               idx_d   = 16'd0;
            end
         end
         S_REGS: begin
            busy  = 1'b1;
            reg_a = idx_q[4:0];
            if (cap) begin
               valid_d = 1'b1;
               kind_d  = 1'b0;
               index_d = idx_q;
               data_d  = reg_rd;
               if (idx_q == REG_LAST) begin
                  state_d = S_MEM;
                  idx_d   = 16'd0;
               end else begin
                  idx_d = idx_q + 16'd1;
               end
            end
         end
         S_MEM: begin
            busy  = 1'b1;
            mem_a = {14'd0, idx_q, 2'b00};
            if (cap) begin
               valid_d = 1'b1;
               kind_d  = 1'b1;
               index_d = idx_q;
               data_d  = mem_rd;
               if (idx_q == MEM_LAST) begin
                  state_d = S_DRAIN;
                  idx_d   = 16'd0;
               end else begin
                  idx_d = idx_q + 16'd1;
               end
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= 16'd0;
         valid_q <= 1'b0;
         kind_q  <= 1'b0;
         index_q <= 16'd0;
         data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         kind_q  <= kind_d;
         index_q <= index_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_kind  = kind_q;
   assign out_index = index_q;
   assign out_data  = data_q;

endmodule

`default_nettype wire
